// File: rtl/multi_target_led_control.sv
// Multi-target LED game controller: spawns, hit detection, timeouts and wrong-press reporting.
// Optional unlit-press reporting is built only when LED_CTRL_WRONG_PRESS_EN is defined.
module multi_target_led_control #(
   parameter int NUM_LEDS      = 18,
   parameter int POS_W         = 5,
   parameter int MAX_ACTIVE    = 3,
   parameter int TIMEOUT_TICKS = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               spawn_tick,
   input  logic [POS_W-1:0]                   random_pos,
   input  logic                               age_tick,
   input  logic [NUM_LEDS-1:0]                sw,
   output logic [NUM_LEDS-1:0]                led_mask,
   output logic [$clog2(MAX_ACTIVE+1)-1:0]    active_count,
   output logic [NUM_LEDS-1:0]                hit_mask,
   output logic [NUM_LEDS-1:0]                miss_mask,
   output logic                               wrong_pulse
);

   localparam int CNT_W = $clog2(MAX_ACTIVE+1);
   localparam int AGE_W = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS+1) : 1;
   localparam logic [AGE_W-1:0] AGE_LAST = (TIMEOUT_TICKS > 0) ? AGE_W'(TIMEOUT_TICKS-1) : '0;

   logic [NUM_LEDS-1:0] s1, s2, s3;
   logic [NUM_LEDS-1:0] press;
   logic [NUM_LEDS-1:0] spawn_vec;
   logic [NUM_LEDS-1:0] expire;
   logic [NUM_LEDS-1:0] hit_nxt, miss_nxt, led_nxt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                spawn_ok;
   logic [AGE_W-1:0]    age     [NUM_LEDS];
   logic [AGE_W-1:0]    age_nxt [NUM_LEDS];

   // All decisions below look only at pre-edge state; results land together at the edge.
   always_comb begin
      press    = s2 & ~s3;
      spawn_ok = spawn_tick && (32'(random_pos) < NUM_LEDS) && (32'(active_count) < MAX_ACTIVE);
      for (int i = 0; i < NUM_LEDS; i++) begin
         spawn_vec[i] = spawn_ok && (32'(random_pos) == i) && !led_mask[i];
         expire[i]    = (TIMEOUT_TICKS > 0) && age_tick && led_mask[i] && (age[i] == AGE_LAST);
         age_nxt[i]   = age[i];
         if (spawn_vec[i])
            age_nxt[i] = '0;
         else if (led_mask[i] && age_tick && !expire[i])
            age_nxt[i] = age[i] + AGE_W'(1);
      end
      // A press beats a simultaneous timeout on the same LED.
      hit_nxt  = led_mask & press;
      miss_nxt = expire & ~press;
      led_nxt  = (led_mask & ~hit_nxt & ~miss_nxt) | spawn_vec;
      cnt_nxt  = '0;
      for (int i = 0; i < NUM_LEDS; i++)
         cnt_nxt = cnt_nxt + CNT_W'(led_nxt[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1           <= '0;
         s2           <= '0;
         s3           <= '0;
         led_mask     <= '0;
         active_count <= '0;
         hit_mask     <= '0;
         miss_mask    <= '0;
         for (int i = 0; i < NUM_LEDS; i++)
            age[i] <= '0;
      end else begin
         s1           <= sw;
         s2           <= s1;
         s3           <= s2;
         led_mask     <= led_nxt;
         active_count <= cnt_nxt;
         hit_mask     <= hit_nxt;
         miss_mask    <= miss_nxt;
         for (int i = 0; i < NUM_LEDS; i++)
            age[i] <= age_nxt[i];
      end
   end

`ifdef LED_CTRL_WRONG_PRESS_EN
   // Any number of unlit presses in one cycle collapse into a single pulse.
   always_ff @(posedge clk) begin
      if (rst)
         wrong_pulse <= 1'b0;
      else
         wrong_pulse <= |(press & ~led_mask);
   end
`else
   assign wrong_pulse = 1'b0;
`endif

endmodule

// File: doc/multi_target_led_control.md
# multi_target_led_control

Parametrised successor to the single-target LED game controller. Lights up to `MAX_ACTIVE` target LEDs at once out of `NUM_LEDS`, from spawn requests issued by the game timer / LFSR. Clears a target when its matching switch sees a synchronised rising edge, or when the target times out. Reports hits, misses and wrong presses to the scoring logic.

## Interface
Parameters:
- `NUM_LEDS`, 18: number of LEDs and switches.
- `POS_W`, 5: width of `random_pos`; must satisfy 2^POS_W ≥ `NUM_LEDS`.
- `MAX_ACTIVE`, 3: maximum simultaneously lit targets (1..`NUM_LEDS`).
- `TIMEOUT_TICKS`, 8: `age_tick` pulses a target survives; 0 disables timeout.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `spawn_tick`  in  1  one-cycle spawn request.
- `random_pos`  in  POS_W  requested LED index, valid with `spawn_tick`.
- `age_tick`  in  1  one-cycle ageing strobe (e.g. 1 ms).
- `sw`  in  NUM_LEDS  raw asynchronous switches.
- `led_mask`  out  NUM_LEDS  registered; bit i = target lit at LED i.
- `active_count`  out  $clog2(MAX_ACTIVE+1)  registered popcount of `led_mask`.
- `hit_mask`  out  NUM_LEDS  one-cycle; bits cleared by a correct press.
- `miss_mask`  out  NUM_LEDS  one-cycle; bits cleared by timeout.
- `wrong_pulse`  out  1  one-cycle; ≥1 rising edge on an unlit switch.

## Operation
- Switch path per bit: 3-FF chain `s1→s2→s3`, all reset to 0. Press event: `s2 & ~s3`.
- Every decision in a cycle uses pre-edge state (`led_mask`, `active_count`, ages). Results land at the next edge.
- Spawn accepted iff all hold:
  - `spawn_tick`=1;
  - `random_pos` < `NUM_LEDS`;
  - `led_mask[random_pos]`=0;
  - `active_count` < `MAX_ACTIVE`.
- Accepted spawn sets the bit and zeroes that LED's age counter. Rejected spawns are silently dropped, with no queueing.
- Press on lit LED i: clear bit i, set `hit_mask[i]`.
- Press on unlit LED: `wrong_pulse`=1 (see Configuration). Multiple in one cycle give a single pulse.
- Ageing: each lit LED has a counter of width $clog2(TIMEOUT_TICKS+1). On `age_tick`:
  - if the counter equals `TIMEOUT_TICKS`-1, clear the bit and set `miss_mask[i]`;
  - otherwise increment.
- Unlit LEDs' counters hold.
- Simultaneous events:
  - hit and timeout on the same LED: hit wins, `miss_mask[i]`=0;
  - spawn on an LED being hit in the same cycle: spawn rejected (already lit);
  - spawn when full while a hit or miss frees a slot in the same cycle: spawn rejected;
  - multiple hits and misses in one cycle: all processed, and the masks carry every bit.
- `active_count` is always the popcount of the registered `led_mask`.
- Reset: `led_mask`, `active_count`, `hit_mask`, `miss_mask`, `wrong_pulse`, ages and sync FFs all 0. Reset mid-game clears all targets at that edge, and no pulses are emitted for them.
- A switch held high through reset produces one press event 2 cycles after the first post-reset edge. This is a wrong press if nothing is lit.

## Timing
- Spawn latency: `spawn_tick` sampled at edge k → `led_mask` bit and `active_count` valid after edge k.
- Press latency: `sw[i]` rises before edge k.
  - `s1`=1 after k, `s2` after k+1.
  - Event seen in cycle k+1→k+2.
  - Bit cleared and `hit_mask[i]` high after edge k+2, for exactly one cycle.
- Minimum press width: 2 clocks. Shorter pulses may be missed.
- Timeout: target spawned at edge k expires at the `TIMEOUT_TICKS`-th `age_tick` sampled after k. Bit cleared and `miss_mask` high after that edge.
- No back-pressure; every input is single-cycle and consumed at once.

## Configuration
- `LED_CTRL_WRONG_PRESS_EN` defined: `wrong_pulse` is driven as above.
- Not defined: `wrong_pulse` is tied to 0 and the unlit-press detection logic is not built. Hit and miss behaviour is unchanged.

## Test plan
- `NUM_LEDS`=18, `MAX_ACTIVE`=3, `TIMEOUT_TICKS`=4. Spawn 7, then 12, then 2 → `led_mask`=0x01084, `active_count`=3. Spawn 5 → ignored, mask unchanged.
- Targets {2,7,12}. Press `sw[3]` for 6 clks → `wrong_pulse` one cycle 3 edges after the rise, mask unchanged. Press 7 → `hit_mask`=0x00080 one cycle, mask=0x01004, count=2.
- Spawn 9, then 4 `age_tick` → on the 4th, `miss_mask`=0x00200, bit 9 cleared. With `TIMEOUT_TICKS`=0, 100 ticks → bit 9 still lit.
- Target 9 at age 3 of 4. Rise `sw[9]` timed so the press event and the 4th `age_tick` coincide → `hit_mask[9]`=1, `miss_mask`=0.
- Full at {1,2,3}. Press 1 and spawn 4 in the same event cycle → 1 cleared, 4 rejected. Spawn 4 next cycle → accepted. `random_pos`=20 → ignored.
- Targets {2,5}. Assert `rst` for 1 clk → all outputs 0 after that edge, with no hit or miss pulses. Build once without `LED_CTRL_WRONG_PRESS_EN`: a wrong press leaves `wrong_pulse`=0.
